// File: rtl/uart_rx_fifo_pkg.sv
// Purpose: shared types and constants for the UART receive FIFO slice.
// Latency: none (package only).
// Backpressure: n/a.
//
// Contents: rx_entry_t (stored byte plus its error flags), the tuser width,
// and the bit positions of the error flags inside tuser.
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_TUSER_W = 2;

    // Bit positions inside m_axis_tuser / the slave-side error flags.
    localparam int TUSER_FRAME  = 1;
    localparam int TUSER_PARITY = 0;

    // Packing order puts {frame_err, parity_err} in the two LSBs, which is
    // exactly the tuser layout, so the flags can be sliced out directly.
    typedef struct packed {
        logic [UART_DATA_W-1:0] data;
        logic                   frame_err;
        logic                   parity_err;
    } rx_entry_t;

    // Either error flag set on an incoming byte.
    function automatic logic has_error(input logic [UART_TUSER_W-1:0] flags);
        return flags[TUSER_FRAME] | flags[TUSER_PARITY];
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Purpose: byte stream bundle (AXI-Stream subset) with per-byte error flags.
// Latency: none (wiring only).
// Backpressure: tready from the slave side; the UART receiver may ignore it.
//
// Signals: tdata (byte), tuser ({frame_err, parity_err}), tvalid, tready.
// Modports: master drives tdata/tuser/tvalid, slave drives tready.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]             tdata;
    logic [uart_pkg::UART_TUSER_W-1:0] tuser;
    logic                              tvalid;
    logic                              tready;

    modport master (
        output tdata,
        output tuser,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// Purpose: simple dual-port register array holding FIFO entries.
// Latency: write lands on the clock edge; read is combinational from rd_addr.
// Backpressure: none; the caller guarantees wr_en only when a slot is free.
//
// Ports: clk, wr_en/wr_addr/wr_data (synchronous write port),
//        rd_addr/rd_data (asynchronous read port, keeps FWFT trivial).
// The array is deliberately not reset; validity is tracked by the pointers.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type ENTRY_T = rx_entry_t
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  ENTRY_T                   wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output ENTRY_T                   rd_data
);

    ENTRY_T mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Purpose: receive-side elastic buffer behind the UART receiver, FWFT stream out.
// Latency: a byte accepted at edge N is on m_axis in cycle N+1 (no empty bypass).
// Backpressure: input cannot be stalled; bytes arriving while full are dropped
//               and flagged in the sticky overrun bit.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_axis (slave)    tdata = byte, tuser = {frame_err, parity_err}, tvalid strobe,
//                     tready = ~full | pop (informational)
//   m_axis (master)   tdata/tuser of the head byte, tvalid = non-empty, tready
//   level             occupancy 0..DEPTH
//   overrun           sticky dropped-byte flag, cleared by overrun_clr
//   overrun_clr       clear request for overrun (a simultaneous new drop wins)
//   err_cnt           saturating count of error-flagged bytes
//
// Build option: defining UART_RX_FIFO_DROP_ERR_EN discards error-flagged bytes
// instead of storing them (still counted), and ties m_axis tuser to zero.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_rx_fifo_if.slave            s_axis,
    uart_rx_fifo_if.master           m_axis,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    input  logic                     overrun_clr,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Same layout as rx_entry_t, but sized by DATA_WIDTH.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  frame_err;
        logic                  parity_err;
    } entry_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    logic   drop;
    logic   in_err;
    logic   err_inc;
    entry_t wr_entry;
    entry_t head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level = wr_ptr - rd_ptr;

    assign pop    = ~empty & m_axis.tready;
    assign in_err = has_error(s_axis.tuser);

    // A pop in the same cycle frees the slot, so a full FIFO still takes a byte.
    assign s_axis.tready = ~full | pop;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    // Error bytes never reach the array and therefore never contribute to overrun.
    assign push    = s_axis.tvalid & ~in_err & (~full | pop);
    assign drop    = s_axis.tvalid & ~in_err & full & ~pop;
    assign err_inc = s_axis.tvalid & in_err;
`else
    assign push    = s_axis.tvalid & (~full | pop);
    assign drop    = s_axis.tvalid & full & ~pop;
    // Only stored bytes are counted; a dropped error byte is lost entirely.
    assign err_inc = push & in_err;
`endif

    always_comb begin
        wr_entry            = '0;
        wr_entry.data       = s_axis.tdata;
        wr_entry.frame_err  = s_axis.tuser[TUSER_FRAME];
        wr_entry.parity_err = s_axis.tuser[TUSER_PARITY];
    end

    uart_fifo_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (head)
    );

    // Pointer update. Modulo arithmetic on PW bits handles wrap of both the
    // address and the wrap bit for any number of passes around the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky overrun: a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Saturating error-byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_inc && (err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign m_axis.tvalid = ~empty;
    assign m_axis.tdata  = head.data;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    // Only clean bytes are stored, so the stored flags carry no information.
    logic unused_head_flags;
    assign unused_head_flags = head.frame_err | head.parity_err;
    assign m_axis.tuser      = '0;
`else
    always_comb begin
        m_axis.tuser               = '0;
        m_axis.tuser[TUSER_FRAME]  = head.frame_err;
        m_axis.tuser[TUSER_PARITY] = head.parity_err;
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: directed self-checking bench for uart_rx_fifo.
// Latency: inputs change 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: m_axis tready is driven directly by the stimulus sequence.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int ECW   = 16;

    logic                   clk;
    logic                   rst;
    logic [$clog2(DEPTH):0] level;
    logic                   overrun;
    logic                   overrun_clr;
    logic [ECW-1:0]         err_cnt;

    uart_rx_fifo_if #(.DATA_WIDTH(DW)) s_if ();
    uart_rx_fifo_if #(.DATA_WIDTH(DW)) m_if ();

    uart_rx_fifo #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .ERR_CNT_WIDTH (ECW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis      (s_if.slave),
        .m_axis      (m_if.master),
        .level       (level),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return just after the edge, away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic [1:0] flags);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tuser  = flags;
        cyc();
        s_if.tvalid = 1'b0;
        s_if.tuser  = 2'b00;
    endtask

    logic [7:0] q[$];
    logic [7:0] rnd_d;
    logic       rnd_v;
    logic       rnd_r;
    logic       mdl_pop;
    logic       mdl_push;
    int         pushes;

    initial begin
        rst          = 1'b1;
        overrun_clr  = 1'b0;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        s_if.tuser   = '0;
        m_if.tready  = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_tvalid",  m_if.tvalid, 1'b0);
        check("rst_level",   level,       0);
        check("rst_overrun", overrun,     1'b0);
        check("rst_err_cnt", err_cnt,     0);
        check("rst_s_tready", s_if.tready, 1'b1);

        // Two clean bytes, consumer always ready
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h55;
        cyc();
        check("b1_tvalid", m_if.tvalid, 1'b1);
        check("b1_tdata",  m_if.tdata,  8'h55);
        check("b1_tuser",  m_if.tuser,  2'b00);
        check("b1_level",  level,       1);
        s_if.tdata = 8'hA3;
        cyc();
        s_if.tvalid = 1'b0;
        check("b2_tdata",  m_if.tdata,  8'hA3);
        check("b2_tuser",  m_if.tuser,  2'b00);
        check("b2_level",  level,       1);
        cyc();
        check("b2_empty",  m_if.tvalid, 1'b0);
        check("b2_level0", level,       0);

        // Fill to full, then one extra byte is dropped
        m_if.tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 2'b00);
        check("full_level", level, 16);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h10;
        #1;
        check("full_s_tready", s_if.tready, 1'b0);
        cyc();
        s_if.tvalid = 1'b0;
        check("ovf_level",   level,   16);
        check("ovf_overrun", overrun, 1'b1);
        check("ovf_err_cnt", err_cnt, 0);
        m_if.tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain1_tvalid", m_if.tvalid, 1'b1);
            check("drain1_tdata",  m_if.tdata,  i);
            cyc();
        end
        check("drain1_empty", m_if.tvalid, 1'b0);

        // Push and pop together while full
        overrun_clr = 1'b1;
        m_if.tready = 1'b0;
        cyc();
        overrun_clr = 1'b0;
        check("clr_overrun", overrun, 1'b0);
        for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i), 2'b00);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h77;
        m_if.tready = 1'b1;
        #1;
        check("pp_s_tready", s_if.tready, 1'b1);
        cyc();
        s_if.tvalid = 1'b0;
        check("pp_level",   level,   16);
        check("pp_overrun", overrun, 1'b0);
        for (int i = 1; i < DEPTH; i++) begin
            check("drain2_tdata", m_if.tdata, 8'h20 + 8'(i));
            cyc();
        end
        check("drain2_last", m_if.tdata, 8'h77);
        cyc();
        check("drain2_empty", m_if.tvalid, 1'b0);

        // Error-flagged bytes
        m_if.tready = 1'b0;
        push_byte(8'h41, 2'b10);
        push_byte(8'h42, 2'b01);
        check("err_cnt2", err_cnt, 2);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        check("err_level", level,       0);
        check("err_tvalid", m_if.tvalid, 1'b0);
        check("err_overrun", overrun,   1'b0);
`else
        check("err_level",  level,      2);
        check("err1_tdata", m_if.tdata, 8'h41);
        check("err1_tuser", m_if.tuser, 2'b10);
        m_if.tready = 1'b1;
        cyc();
        check("err2_tdata", m_if.tdata, 8'h42);
        check("err2_tuser", m_if.tuser, 2'b01);
        cyc();
        check("err_empty", m_if.tvalid, 1'b0);
`endif

        // Overrun set beats clear in the same cycle
        m_if.tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_byte(8'hC0 + 8'(i), 2'b00);
        push_byte(8'hEE, 2'b00);
        check("ovr_set", overrun, 1'b1);
        overrun_clr = 1'b1;
        push_byte(8'hEF, 2'b00);
        check("ovr_set_wins", overrun, 1'b1);
        cyc();
        overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 1'b0);
        check("ovr_level",   level,   16);

        // Drain before the random phase
        m_if.tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) cyc();
        check("pre_rnd_level", level, 0);

        // Random traffic against a queue model; repeated pointer wrap
        pushes = 0;
        for (int c = 0; c < 2000 && pushes < 100; c++) begin
            rnd_v = 1'($urandom_range(0, 1));
            rnd_r = 1'($urandom_range(0, 1));
            rnd_d = 8'($urandom);
            s_if.tvalid = rnd_v;
            s_if.tdata  = rnd_d;
            m_if.tready = rnd_r;
            #1;
            mdl_pop  = (q.size() > 0) && rnd_r;
            mdl_push = rnd_v && ((q.size() < DEPTH) || mdl_pop);
            if (mdl_pop) check("rnd_head", m_if.tdata, q[0]);
            cyc();
            if (mdl_pop) void'(q.pop_front());
            if (mdl_push) begin
                q.push_back(rnd_d);
                pushes++;
            end
            check("rnd_level", level, q.size());
        end
        check("rnd_done", pushes, 100);

        // Reset mid-stream with data held
        m_if.tready = 1'b0;
        push_byte(8'h5A, 2'b00);
        check("mid_nonempty", m_if.tvalid, 1'b1);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h66;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        s_if.tvalid = 1'b0;
        check("mrst_tvalid",  m_if.tvalid, 1'b0);
        check("mrst_level",   level,       0);
        check("mrst_overrun", overrun,     1'b0);
        check("mrst_err_cnt", err_cnt,     0);
        push_byte(8'h99, 2'b00);
        check("post_tvalid", m_if.tvalid, 1'b1);
        check("post_tdata",  m_if.tdata,  8'h99);
        check("post_level",  level,       1);
        m_if.tready = 1'b1;
        cyc();
        check("post_empty", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
